// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot occupancy logic and the display logic:
// debounce state encoding and default lot parameters.
package parking_pkg;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_CONF_HI,
    DB_HIGH,
    DB_CONF_LO
  } db_state_e;

  localparam int DEF_CAPACITY       = 8;
  localparam int DEF_DEBOUNCE_TICKS = 3;
  localparam int DEF_CNT_W          = 4;

endpackage

// File: rtl/sensor_debouncer.sv
// Synchronises one raw vehicle sensor, debounces it on the 100 Hz tick and
// emits a one-cycle pulse on each accepted rising edge.
module sensor_debouncer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_100hz,
  input  logic raw_in,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_q;
  logic          sync;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_d;

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_in};
    end
  end

  assign sync = sync_q[1];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (tick_100hz) begin
      case (state_q)
        DB_LOW: begin
          if (sync) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_d = DB_HIGH;
              cnt_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = DB_CONF_HI;
              cnt_d   = CW'(1);
            end
          end
        end
        DB_CONF_HI: begin
          if (!sync) begin
            state_d = DB_LOW;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = DB_HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DB_HIGH: begin
          if (!sync) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_d = DB_LOW;
              cnt_d   = '0;
            end else begin
              state_d = DB_CONF_LO;
              cnt_d   = CW'(1);
            end
          end
        end
        DB_CONF_LO: begin
          // Bouncing back high is not a new edge, so no pulse here.
          if (sync) begin
            state_d = DB_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = DB_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= DB_LOW;
      cnt_q      <= '0;
      rise_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rise_pulse <= rise_d;
    end
  end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Lot occupancy counter: debounced entry/exit events update a saturating count
// with registered free-slot, full/empty flags and a reject pulse.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY       = DEF_CAPACITY,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_100hz,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  output logic [CNT_W-1:0] occupied,
  output logic [CNT_W-1:0] free_slots,
  output logic             full,
  output logic             empty,
  output logic             entry_event,
  output logic             exit_event,
  output logic             reject
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] occ_d;
  logic             reject_d;

  sensor_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_entry_db (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_100hz (tick_100hz),
    .raw_in     (entry_sensor),
    .rise_pulse (entry_event)
  );

  sensor_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_exit_db (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_100hz (tick_100hz),
    .raw_in     (exit_sensor),
    .rise_pulse (exit_event)
  );

  // Simultaneous entry and exit cancel out, even at the full/empty limits.
  always_comb begin
    occ_d    = occupied;
    reject_d = 1'b0;
    case ({entry_event, exit_event})
      2'b10: begin
        if (full) reject_d = 1'b1;
        else      occ_d    = occupied + CNT_W'(1);
      end
      2'b01: begin
        if (!empty) occ_d = occupied - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      occupied   <= '0;
      free_slots <= CAP_V;
      full       <= 1'b0;
      empty      <= 1'b1;
      reject     <= 1'b0;
    end else begin
      occupied   <= occ_d;
      free_slots <= CAP_V - occ_d;
      full       <= (occ_d == CAP_V);
      empty      <= (occ_d == '0);
      reject     <= reject_d;
    end
  end

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Self-checking bench: directed and random sensor levels, one tick every 10 cycles,
// compared against a run-length debounce and saturating occupancy model.
module tb_parking_occupancy_counter;

  localparam int CAP = 8;
  localparam int DT  = 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_100hz = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [3:0] occupied, free_slots;
  logic       full, empty, entry_event, exit_event, reject;

  int checks   = 0;
  int failures = 0;

  // Reference model state: accepted level and length of the disagreeing run per sensor.
  bit acc_e, acc_x;
  int run_e, run_x;
  int m_occ;
  bit m_rej;

  parking_occupancy_counter #(.CAPACITY(CAP), .DEBOUNCE_TICKS(DT), .CNT_W(4)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .tick_100hz   (tick_100hz),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .occupied     (occupied),
    .free_slots   (free_slots),
    .full         (full),
    .empty        (empty),
    .entry_event  (entry_event),
    .exit_event   (exit_event),
    .reject       (reject)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    acc_e = 0; acc_x = 0; run_e = 0; run_x = 0; m_occ = 0; m_rej = 0;
  endtask

  // A level is accepted after DT consecutive ticks that disagree with the current one.
  task automatic model_sensor(input bit lvl, inout bit acc, inout int run, output bit ev);
    ev = 0;
    if (lvl != acc) run++;
    else            run = 0;
    if (run == DT) begin
      acc = lvl;
      run = 0;
      ev  = lvl;
    end
  endtask

  task automatic model_occ(input bit ee, input bit ex);
    m_rej = 0;
    if (ee && !ex) begin
      if (m_occ == CAP) m_rej = 1;
      else              m_occ++;
    end else if (ex && !ee) begin
      if (m_occ > 0) m_occ--;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_occupied"}, occupied, m_occ);
    check({tag, "_free"}, free_slots, CAP - m_occ);
    check({tag, "_full"}, full, m_occ == CAP);
    check({tag, "_empty"}, empty, m_occ == 0);
    check({tag, "_reject"}, reject, m_rej);
  endtask

  // One tick period: set sensor levels, tick on the 8th cycle, check events then occupancy.
  task automatic step(input bit e, input bit x);
    bit ee, ex;
    @(negedge clk_in);
    check("idle_entry_event", entry_event, 0);
    check("idle_exit_event", exit_event, 0);
    check("idle_reject", reject, 0);
    entry_sensor = e;
    exit_sensor  = x;
    repeat (7) @(negedge clk_in);
    tick_100hz = 1'b1;
    @(negedge clk_in);
    tick_100hz = 1'b0;
    model_sensor(e, acc_e, run_e, ee);
    model_sensor(x, acc_x, run_x, ex);
    check("entry_event", entry_event, ee);
    check("exit_event", exit_event, ex);
    model_occ(ee, ex);
    @(negedge clk_in);
    check("post_entry_event", entry_event, 0);
    check("post_exit_event", exit_event, 0);
    check_state("upd");
  endtask

  task automatic pulse(input bit e, input bit x);
    repeat (DT) step(e, x);
    repeat (DT) step(0, 0);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk_in);
    entry_sensor = 0;
    exit_sensor  = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    check({tag, "_entry_event"}, entry_event, 0);
    check({tag, "_exit_event"}, exit_event, 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_in);
    check_state("reset");
    rst = 1'b0;

    // Exit from an empty lot is ignored.
    pulse(0, 1);
    check("t5_empty", empty, 1);

    // Entry held four ticks: single event on the third.
    repeat (4) step(1, 0);
    repeat (DT) step(0, 0);
    check("t2_occupied", occupied, 1);
    check("t2_free", free_slots, 7);

    // Two ticks high then low: no event.
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    check("t3_occupied", occupied, 1);

    // Reset mid-debounce abandons the partial run.
    step(1, 0); step(1, 0);
    async_reset("mid_reset");
    step(1, 0);
    repeat (DT) step(0, 0);

    // Fill to capacity, then one rejected entry.
    repeat (CAP) pulse(1, 0);
    check("t4_full", full, 1);
    check("t4_occupied", occupied, 8);
    pulse(1, 0);
    check("t4_occ_after_reject", occupied, 8);

    // Entry and exit together while full.
    pulse(1, 1);
    check("t6_occupied", occupied, 8);
    check("t6_full", full, 1);

    // Random sensor levels with a bias toward holding the current level.
    for (int i = 0; i < 150; i++) begin
      bit e, x;
      e = ($urandom_range(0, 3) == 0) ? !entry_sensor : entry_sensor;
      x = ($urandom_range(0, 3) == 0) ? !exit_sensor : exit_sensor;
      step(e, x);
    end

    async_reset("end_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
